// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//   Single-clock FIFO with a registered read port, occupancy counter and
//   almost-full / almost-empty watermarks.
//
// Parameters
//   WIDTH      data word width in bits (>= 1)
//   DEPTH      number of entries, power of two, >= 4
//   AF_THRESH  almost_full asserts when occupancy >= AF_THRESH
//   AE_THRESH  almost_empty asserts when occupancy <= AE_THRESH
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   buf_in        write data, captured when a write is accepted
//   wr_en         write request
//   rd_en         read request
//   buf_out       registered read data, holds when no read is accepted
//   buf_empty     occupancy == 0
//   buf_full      occupancy == DEPTH
//   almost_full   occupancy >= AF_THRESH
//   almost_empty  occupancy <= AE_THRESH
//   fifo_counter  occupancy, 0..DEPTH
//   overflow      one-cycle pulse after an edge that rejected a write
//   underflow     one-cycle pulse after an edge that rejected a read
// -----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] buf_in,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] buf_out,
    output logic             buf_empty,
    output logic             buf_full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    fifo_counter,
    output logic             overflow,
    output logic             underflow
);

    // Storage has no reset so it can map onto RAM; stale words are
    // unreachable once the pointers and counter are cleared.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic rd_acc;
    logic wr_acc;

    // A read frees a slot on the same edge, so a full FIFO can still take
    // a write when it is also being read. An empty FIFO never serves a read
    // from the word written on the same edge (no fall-through).
    assign rd_acc = rd_en && !buf_empty;
    assign wr_acc = wr_en && (!buf_full || rd_acc);

    // Status decodes straight from the registered counter, so every flag
    // reflects the state left by the previous edge.
    assign buf_empty    = (fifo_counter == '0);
    assign buf_full     = (fifo_counter == CW'(DEPTH));
    assign almost_full  = (fifo_counter >= CW'(AF_THRESH));
    assign almost_empty = (fifo_counter <= CW'(AE_THRESH));

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= buf_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
            buf_out      <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + AW'(1);
                buf_out <= mem[rd_ptr];
            end

            // Simultaneous accepted read and write leaves occupancy as is.
            case ({wr_acc, rd_acc})
                2'b10:   fifo_counter <= fifo_counter + CW'(1);
                2'b01:   fifo_counter <= fifo_counter - CW'(1);
                default: fifo_counter <= fifo_counter;
            endcase

            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && !rd_acc;
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//   Two instances: default geometry (DEPTH=64) and a DEPTH=4 copy for quick
//   pointer-wrap coverage. Each is compared against a queue-based model that
//   applies the FIFO acceptance rules directly.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

    localparam int D0 = 64, AF0 = 56, AE0 = 8;
    localparam int D1 = 4,  AF1 = 3,  AE1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
    logic [7:0] din0 = '0, din1 = '0;
    logic [7:0] out0, out1;
    logic       e0, f0, af0, ae0, ov0, un0;
    logic       e1, f1, af1, ae1, ov1, un1;
    logic [6:0] cnt0;
    logic [2:0] cnt1;

    fifo_sync_param #(.WIDTH(8), .DEPTH(D0), .AF_THRESH(AF0), .AE_THRESH(AE0)) u_dut (
        .clk(clk), .rst(rst), .buf_in(din0), .wr_en(wr0), .rd_en(rd0),
        .buf_out(out0), .buf_empty(e0), .buf_full(f0), .almost_full(af0),
        .almost_empty(ae0), .fifo_counter(cnt0), .overflow(ov0), .underflow(un0)
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH(D1), .AF_THRESH(AF1), .AE_THRESH(AE1)) u_d4 (
        .clk(clk), .rst(rst), .buf_in(din1), .wr_en(wr1), .rd_en(rd1),
        .buf_out(out1), .buf_empty(e1), .buf_full(f1), .almost_full(af1),
        .almost_empty(ae1), .fifo_counter(cnt1), .overflow(ov1), .underflow(un1)
    );

    int checks = 0;
    int errors = 0;

    // reference state
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] mo0 = '0, mo1 = '0;
    bit         mov0 = 0, mun0 = 0, mov1 = 0, mun1 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input int sel, input string tag);
        if (sel == 0) begin
            chk({tag, " d64 out"},   32'(out0), 32'(mo0));
            chk({tag, " d64 cnt"},   32'(cnt0), 32'(q0.size()));
            chk({tag, " d64 empty"}, 32'(e0),   32'(q0.size() == 0));
            chk({tag, " d64 full"},  32'(f0),   32'(q0.size() == D0));
            chk({tag, " d64 af"},    32'(af0),  32'(q0.size() >= AF0));
            chk({tag, " d64 ae"},    32'(ae0),  32'(q0.size() <= AE0));
            chk({tag, " d64 ovf"},   32'(ov0),  32'(mov0));
            chk({tag, " d64 unf"},   32'(un0),  32'(mun0));
        end else begin
            chk({tag, " d4 out"},    32'(out1), 32'(mo1));
            chk({tag, " d4 cnt"},    32'(cnt1), 32'(q1.size()));
            chk({tag, " d4 empty"},  32'(e1),   32'(q1.size() == 0));
            chk({tag, " d4 full"},   32'(f1),   32'(q1.size() == D1));
            chk({tag, " d4 af"},     32'(af1),  32'(q1.size() >= AF1));
            chk({tag, " d4 ae"},     32'(ae1),  32'(q1.size() <= AE1));
            chk({tag, " d4 ovf"},    32'(ov1),  32'(mov1));
            chk({tag, " d4 unf"},    32'(un1),  32'(mun1));
        end
    endtask

    // One clock with the given request on the selected instance; the other
    // instance sits idle.
    task automatic step(input int sel, input bit wr, input bit rd, input logic [7:0] d,
                        input string tag);
        bit rok, wok;
        if (sel == 0) begin
            wr0 = wr; rd0 = rd; din0 = d; wr1 = 1'b0; rd1 = 1'b0;
        end else begin
            wr1 = wr; rd1 = rd; din1 = d; wr0 = 1'b0; rd0 = 1'b0;
        end
        @(posedge clk);
        if (sel == 0) begin
            rok = rd && (q0.size() > 0);
            wok = wr && (q0.size() < D0 || rok);
            if (rok) mo0 = q0.pop_front();
            if (wok) q0.push_back(d);
            mov0 = wr && !wok;
            mun0 = rd && !rok;
            mov1 = 0; mun1 = 0;
        end else begin
            rok = rd && (q1.size() > 0);
            wok = wr && (q1.size() < D1 || rok);
            if (rok) mo1 = q1.pop_front();
            if (wok) q1.push_back(d);
            mov1 = wr && !wok;
            mun1 = rd && !rok;
            mov0 = 0; mun0 = 0;
        end
        #1;
        check_all(sel, tag);
    endtask

    task automatic do_reset(input int sel, input bit wr, input string tag);
        rst = 1'b1;
        wr0 = (sel == 0) && wr; rd0 = 1'b0; din0 = 8'hA5;
        wr1 = (sel == 1) && wr; rd1 = 1'b0; din1 = 8'h5A;
        @(posedge clk);
        q0.delete(); q1.delete();
        mo0 = '0; mo1 = '0;
        mov0 = 0; mun0 = 0; mov1 = 0; mun1 = 0;
        #1;
        rst = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        check_all(0, tag);
        check_all(1, tag);
    endtask

    initial begin
        int pw, pr;

        do_reset(0, 0, "rst0");
        do_reset(0, 0, "rst1");

        // read on empty after reset
        step(0, 0, 1, 8'h00, "unf_empty");
        step(0, 0, 0, 8'h00, "unf_clear");

        // three writes then three reads
        step(0, 1, 0, 8'h11, "w11");
        step(0, 1, 0, 8'h22, "w22");
        step(0, 1, 0, 8'h33, "w33");
        step(0, 0, 1, 8'h00, "r1");
        step(0, 0, 1, 8'h00, "r2");
        step(0, 0, 1, 8'h00, "r3");

        // fill to 64, then one rejected write, then idle
        for (int i = 0; i < D0; i++) step(0, 1, 0, 8'($urandom), "fill");
        step(0, 1, 0, 8'hEE, "ovf");
        step(0, 0, 0, 8'h00, "ovf_clear");

        // simultaneous read/write while full
        for (int i = 0; i < 10; i++) step(0, 1, 1, 8'($urandom), "full_rw");

        // drain, then simultaneous read/write while empty
        for (int i = 0; i < D0; i++) step(0, 0, 1, 8'h00, "drain");
        step(0, 1, 1, 8'h77, "empty_rw");
        step(0, 0, 0, 8'h00, "empty_rw_idle");

        // randomized phases: fill-biased then drain-biased, repeated
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 2 == 0) ? 80 : 25;
            pr = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 120; i++)
                step(0, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     8'($urandom), "rand64");
        end

        // reset mid-operation with a write pending, occupancy 5
        do_reset(0, 0, "rst2");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h40 + i), "pre_rst_w");
        step(0, 0, 1, 8'h00, "pre_rst_r");
        step(0, 1, 0, 8'h4F, "pre_rst_w5");
        do_reset(0, 1, "rst_mid");
        step(0, 0, 0, 8'h00, "post_rst_idle");

        // DEPTH=4 wrap: write 4, read 2, write 2, read 4
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'(8'hA0 + i), "d4_w4");
        step(1, 1, 0, 8'hFF, "d4_ovf");
        for (int i = 0; i < 2; i++) step(1, 0, 1, 8'h00, "d4_r2");
        for (int i = 0; i < 2; i++) step(1, 1, 0, 8'(8'hB0 + i), "d4_w2");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 8'h00, "d4_r4");
        step(1, 0, 1, 8'h00, "d4_unf");

        for (int i = 0; i < 300; i++)
            step(1, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 8'($urandom), "rand4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 64, number of entries; power of two, >=4.
REQ-003 Parameter AF_THRESH, default 56, almost-full level (1..DEPTH-1).
REQ-004 Parameter AE_THRESH, default 8, almost-empty level (1..DEPTH-1).
REQ-005 CW = log2(DEPTH)+1 SHALL be the occupancy width (7 at default).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 buf_in  input  WIDTH  write data, sampled when a write is accepted.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request.
REQ-011 buf_out  output  WIDTH  registered read data.
REQ-012 buf_empty  output  1  high when fifo_counter == 0.
REQ-013 buf_full  output  1  high when fifo_counter == DEPTH.
REQ-014 almost_full  output  1  high when fifo_counter >= AF_THRESH.
REQ-015 almost_empty  output  1  high when fifo_counter <= AE_THRESH.
REQ-016 fifo_counter  output  CW  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse: write rejected.
REQ-018 underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-019 Write accepted iff wr_en=1 and (buf_full=0 or read accepted same cycle); buf_in stored at write pointer, pointer +1 mod DEPTH.
REQ-020 Read accepted iff rd_en=1 and buf_empty=0; entry at read pointer loaded into buf_out at that edge, pointer +1 mod DEPTH.
REQ-021 Read latency: data visible on buf_out the cycle after the accepting edge; buf_out holds its value when no read is accepted.
REQ-022 fifo_counter: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH or drops below 0.
REQ-023 Simultaneous wr_en and rd_en when empty: write only accepted, counter 0->1, underflow pulses, buf_out unchanged (no fall-through).
REQ-024 Simultaneous wr_en and rd_en when full: both accepted, counter stays DEPTH, no overflow.
REQ-025 Simultaneous wr_en and rd_en when partially filled: both accepted, counter unchanged.
REQ-026 wr_en=1 while full without read: data dropped, memory and pointers unchanged, overflow=1 for exactly that cycle.
REQ-027 rd_en=1 while empty: no state change except underflow=1 for that cycle.
REQ-028 All status flags SHALL derive from the registered counter, valid the cycle after the causing edge.
REQ-029 Pointers wrap from DEPTH-1 to 0 with no data loss or reordering; order is strictly first-in first-out.

Reset
REQ-030 On rst=1 at a rising edge: fifo_counter=0, pointers=0, buf_out=0, buf_empty=1, almost_empty=1, buf_full=0, almost_full=0, overflow=0, underflow=0.
REQ-031 rst has priority over wr_en/rd_en in the same cycle; reset mid-operation discards all stored entries; memory contents need not be cleared.

Verification
REQ-032 Reset, then write 0x11,0x22,0x33 on three edges, then read three -> buf_out 0x11,0x22,0x33 one cycle after each read edge; counter 1,2,3,2,1,0.
REQ-033 Write 64 words (default) -> buf_full=1 at counter 64, almost_full rises when counter reaches 56; 65th write -> overflow pulse one cycle, counter stays 64.
REQ-034 Read on empty after reset -> underflow pulse, counter 0, buf_out 0x00.
REQ-035 Full FIFO, wr_en=rd_en=1 for 10 cycles -> counter stays 64, outputs read in FIFO order, no overflow; empty FIFO same stimulus for one cycle -> counter 1, underflow pulse.
REQ-036 DEPTH=4: write 4, read 2, write 2, read 4 -> pointer wrap, data order preserved, buf_empty=1 at end.
REQ-037 Assert rst with counter 5 while wr_en=1 -> next cycle counter 0, buf_empty=1, buf_out 0x00.
